sqrt_arbiter: RTL



---
 rtl/sqrt_arbiter_pkg.sv | 25 ++
 rtl/isqrt_core.sv | 57 +++++
 rtl/sqrt_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/sqrt_arbiter_pkg.sv
// sqrt_arbiter_pkg: shared state encoding, default widths, requester indices and the round-robin pick
package sqrt_arbiter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int NBITS_DEF = 21;
   localparam int MBITS_DEF = (NBITS_DEF + 1) / 2;

   localparam logic [1:0] REQ_AD = 2'd0;
   localparam logic [1:0] REQ_BC = 2'd1;
   localparam logic [1:0] REQ_IT = 2'd2;

   // Walks last+3, last+2, last+1 (mod 3) so the nearest active requester after last wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
      logic [1:0] pick;
      logic [1:0] j;
      pick = last;
      for (int k = 2; k >= 0; k--) begin
         j = 2'((int'(last) + 1 + k) % 3);
         if (req[j]) pick = j;
      end
      return pick;
   endfunction

endpackage

// File: rtl/isqrt_core.sv
// isqrt_core: iterative MSB-first bit-trial integer square root, one result bit per cycle
//   clk, reset : clock, synchronous active-high reset
//   start      : load operand and begin at bit MBITS-1
//   operand    : value to root, sampled on start
//   answer     : running result including the current cycle's trial
//   done       : high in the cycle the last bit is decided; answer is final then
module isqrt_core
   import sqrt_arbiter_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int MBITS = (NBITS + 1) / 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [NBITS-1:0] operand,
   output logic [MBITS-1:0] answer,
   output logic             done
);

   localparam int PW = 2 * MBITS;
   localparam int BW = $clog2(MBITS + 1);

   logic             run_q, run_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [MBITS-1:0] ans_q, ans_d, trial;
   logic [PW-1:0]    op_q, op_d, sq;
   logic             take;

   // answer/done are combinational so the caller can latch the final bit in the same cycle
   always_comb begin
      trial  = ans_q | (MBITS'(1) << bit_q);
      sq     = PW'(trial) * PW'(trial);
      take   = run_q && (sq <= op_q);
      answer = take ? trial : ans_q;
      done   = run_q && (bit_q == '0);
      run_d  = start || (run_q && (bit_q != '0));
      bit_d  = start ? BW'(MBITS - 1) : run_q ? bit_q - BW'(1) : bit_q;
      ans_d  = start ? '0 : answer;
      op_d   = start ? PW'(operand) : op_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q <= 1'b0;
         bit_q <= '0;
         ans_q <= '0;
         op_q  <= '0;
      end else begin
         run_q <= run_d;
         bit_q <= bit_d;
         ans_q <= ans_d;
         op_q  <= op_d;
      end
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one isqrt_core among the AD, BC and iterator requesters
//   clk, reset             : clock, synchronous active-high reset
//   req[2:0]               : request per requester (0 AD, 1 BC, 2 iterator), sampled in IDLE
//   data_a, data_b, data_c : operands of requesters 0, 1, 2
//   ack[2:0]               : one-cycle pulse, operand of requester i captured
//   valid[2:0]             : one-cycle pulse, answer belongs to requester i
//   answer                 : floor(sqrt(operand)), held until the next valid
//   busy                   : high in RUN and DONE
module sqrt_arbiter
   import sqrt_arbiter_pkg::*;
#(
   parameter int NBITS = NBITS_DEF,
   parameter int MBITS = (NBITS + 1) / 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       req,
   input  logic [NBITS-1:0] data_a,
   input  logic [NBITS-1:0] data_b,
   input  logic [NBITS-1:0] data_c,
   output logic [2:0]       ack,
   output logic [2:0]       valid,
   output logic [MBITS-1:0] answer,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [1:0]       last_q, last_d, idx_q, idx_d, gidx;
   logic [2:0]       ack_q, ack_d, valid_q, valid_d;
   logic [MBITS-1:0] answer_q, answer_d, core_answer;
   logic             busy_q, busy_d, start, core_done;
   logic [NBITS-1:0] operand;

   assign ack    = ack_q;
   assign valid  = valid_q;
   assign answer = answer_q;
   assign busy   = busy_q;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      idx_d    = idx_q;
      ack_d    = '0;
      valid_d  = '0;
      answer_d = answer_q;
      start    = 1'b0;
      gidx     = rr_pick(last_q, req);
      operand  = (gidx == REQ_AD) ? data_a : (gidx == REQ_BC) ? data_b : data_c;
      case (state_q)
         IDLE: if (|req) begin
            state_d = RUN;
            ack_d   = 3'(1) << gidx;
            idx_d   = gidx;
            last_d  = gidx;
            start   = 1'b1;
         end
         RUN: if (core_done) begin
            state_d  = DONE;
            valid_d  = 3'(1) << idx_q;
            answer_d = core_answer;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= REQ_IT;
         idx_q    <= REQ_AD;
         ack_q    <= '0;
         valid_q  <= '0;
         answer_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         ack_q    <= ack_d;
         valid_q  <= valid_d;
         answer_q <= answer_d;
         busy_q   <= busy_d;
      end
   end

   isqrt_core #(.NBITS(NBITS), .MBITS(MBITS)) u_core (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .operand (operand),
      .answer  (core_answer),
      .done    (core_done)
   );

endmodule
